srpt_rank_calc: RTL and testbench
=================================

// Module: srpt_rank_calc
// PURPOSE
//  Upstream of rank_pipe: turns per-packet descriptors into rank_pipe insert requests.
//  Keeps a per-flow remaining-bytes table, computes the SRPT rank and drives rank_pipe's
//  insert/meta_in/rank_op_in/srpt_rank_in. Obeys rank_pipe's busy backpressure.
// PARAMETERS
//  NUM_FLOWS_BITS  4   log2 of flow-table entries (16 flows)
//  LEN_WIDTH       16  packet length width, bytes
//  SIZE_WIDTH      32  flow size / remaining-bytes width
//  RANK_WIDTH      16  rank width; must match rank_pipe
//  META_WIDTH      16  metadata width; must match rank_pipe
//  RANK_CODE_BITS  2   rank op code width; must match rank_pipe
//  SRPT_OP         0   op code sent for known flows
//  FIFO_OP         1   op code sent for unknown flows
// PORTS
//  clk            in   1               clock
//  rst            in   1               synchronous reset, active high
//  in_valid       in   1               descriptor valid
//  in_ready       out  1               descriptor accepted when in_valid & in_ready
//  in_flow_id     in   NUM_FLOWS_BITS  flow index
//  in_pkt_len     in   LEN_WIDTH       packet bytes
//  in_flow_size   in   SIZE_WIDTH      total flow bytes; used only when in_first=1
//  in_first       in   1               first packet of flow
//  in_last        in   1               last packet of flow
//  in_meta        in   META_WIDTH      passed to meta_out unchanged
//  busy           in   1               rank_pipe busy
//  insert         out  1               rank_pipe insert strobe
//  meta_out       out  META_WIDTH      -> rank_pipe meta_in
//  rank_op_out    out  RANK_CODE_BITS  -> rank_pipe rank_op_in
//  srpt_rank_out  out  RANK_WIDTH      -> rank_pipe srpt_rank_in
//  err_count      out  16              count of non-first packets to unknown flows
// BEHAVIOUR
//  Reset (synchronous, active high): all rem[] = 0, all vld[] = 0, pending = 0,
//    err_count = 0. insert = 0 and in_ready = 1 in the first cycle after reset.
//    Reset mid-operation drops the pending descriptor with no insert.
//  Output stage: one-entry register (pending + meta/op/rank).
//    insert = pending & ~busy; in_ready = ~pending | ~busy (combinational).
//    Accept with pending already set replaces it in the same cycle the old one inserts.
//    Outputs hold while pending & busy.
//  Latency: accept on cycle N -> pending set at N+1; insert at N+1 if busy=0.
//  Rank computation on accept (combinational read; table written at the same edge):
//    base = in_first ? in_flow_size : rem[id]
//    known = in_first | vld[id]
//    srpt_rank = known ? min(base, 2^RANK_WIDTH-1) : all ones
//    rank_op = known ? SRPT_OP : FIFO_OP
//    Rank is the bytes remaining before this packet.
//  Table update on accept, when known:
//    rem[id] = base - in_pkt_len, saturating at 0.
//    vld[id] = ~in_last; in_last also forces rem[id] = 0.
//  Unknown non-first packet: table unchanged; err_count += 1, saturating at 16'hFFFF.
//  Back-to-back packets of one flow: the second sees the updated rem; no bubble.
//  in_first on an already valid flow overwrites the entry (restart).
//  in_first & in_last together: single-packet flow; rank = flow_size; entry ends invalid.
//  No descriptor is dropped or duplicated. Inserts match the order of accepts.
// TESTING
//  1. first id3 size 3000 len 1000, then id3 len 1000 x2 (last on 3rd), busy=0
//     -> ranks 3000, 2000, 1000, op=SRPT_OP; vld[3]=0 afterwards.
//  2. non-first id5 after reset -> rank 16'hFFFF, op=FIFO_OP, err_count=1, rem[5] stays 0.
//  3. busy=1 for 5 cycles with 3 descriptors offered
//     -> 1 pending, in_ready=0, insert=0; after busy drops, 3 inserts in order, none lost.
//  4. size 70000 first len 1500 -> rank saturates to 65535; next packet rank 65535
//     (68500 clipped); len > rem -> rem saturates at 0.
//  5. flows 1 and 2 interleaved every cycle, busy toggling randomly
//     -> per-flow ranks strictly decreasing by pkt_len; insert count equals accept count.
//  6. rst asserted while pending & busy -> next cycle insert=0, in_ready=1, table cleared.

Source files
------------

// File: rtl/srpt_rank_calc.sv
// SRPT rank calculator: per-flow remaining-bytes table feeding
// rank_pipe insert requests through a one-entry output register.
module srpt_rank_calc #(
  parameter int NUM_FLOWS_BITS = 4,
  parameter int LEN_WIDTH      = 16,
  parameter int SIZE_WIDTH     = 32,
  parameter int RANK_WIDTH     = 16,
  parameter int META_WIDTH     = 16,
  parameter int RANK_CODE_BITS = 2,
  parameter logic [RANK_CODE_BITS-1:0] SRPT_OP = RANK_CODE_BITS'(0),
  parameter logic [RANK_CODE_BITS-1:0] FIFO_OP = RANK_CODE_BITS'(1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [NUM_FLOWS_BITS-1:0] in_flow_id,
  input  logic [LEN_WIDTH-1:0]      in_pkt_len,
  input  logic [SIZE_WIDTH-1:0]     in_flow_size,
  input  logic                      in_first,
  input  logic                      in_last,
  input  logic [META_WIDTH-1:0]     in_meta,
  input  logic                      busy,
  output logic                      insert,
  output logic [META_WIDTH-1:0]     meta_out,
  output logic [RANK_CODE_BITS-1:0] rank_op_out,
  output logic [RANK_WIDTH-1:0]     srpt_rank_out,
  output logic [15:0]               err_count
);

  localparam int NF = 1 << NUM_FLOWS_BITS;
  localparam logic [SIZE_WIDTH-1:0] RMAX =
    SIZE_WIDTH'({RANK_WIDTH{1'b1}});

  logic [SIZE_WIDTH-1:0]     rem_q [NF];
  logic [SIZE_WIDTH-1:0]     rem_d [NF];
  logic [NF-1:0]             vld_q, vld_d;
  logic                      pend_q, pend_d;
  logic [META_WIDTH-1:0]     meta_q, meta_d;
  logic [RANK_CODE_BITS-1:0] op_q, op_d;
  logic [RANK_WIDTH-1:0]     rank_q, rank_d;
  logic [15:0]               err_q, err_d;

  logic                      accept;
  logic                      known;
  logic [SIZE_WIDTH-1:0]     base;
  logic [SIZE_WIDTH-1:0]     len_ext;
  logic [SIZE_WIDTH-1:0]     rem_nxt;

  assign insert        = pend_q & ~busy;
  assign in_ready      = ~pend_q | ~busy;
  assign accept        = in_valid & in_ready;
  assign meta_out      = meta_q;
  assign rank_op_out   = op_q;
  assign srpt_rank_out = rank_q;
  assign err_count     = err_q;

  // Rank lookup, table update and output-register next state
  always_comb begin
    rem_d   = rem_q;
    vld_d   = vld_q;
    pend_d  = pend_q;
    meta_d  = meta_q;
    op_d    = op_q;
    rank_d  = rank_q;
    err_d   = err_q;
    base    = in_first ? in_flow_size : rem_q[in_flow_id];
    known   = in_first | vld_q[in_flow_id];
    len_ext = SIZE_WIDTH'(in_pkt_len);
    rem_nxt = (in_last || base < len_ext) ? '0 : base - len_ext;
    if (accept) begin
      pend_d = 1'b1;
      meta_d = in_meta;
      if (known) begin
        op_d   = SRPT_OP;
        rank_d = (base > RMAX) ? '1 : base[RANK_WIDTH-1:0];
        rem_d[in_flow_id] = rem_nxt;
        vld_d[in_flow_id] = ~in_last;
      end else begin
        op_d   = FIFO_OP;
        rank_d = '1;
        if (err_q != 16'hFFFF) err_d = err_q + 16'd1;
      end
    end else if (insert) begin
      pend_d = 1'b0;
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      rem_q  <= '{default: '0};
      vld_q  <= '0;
      pend_q <= 1'b0;
      meta_q <= '0;
      op_q   <= '0;
      rank_q <= '0;
      err_q  <= '0;
    end else begin
      rem_q  <= rem_d;
      vld_q  <= vld_d;
      pend_q <= pend_d;
      meta_q <= meta_d;
      op_q   <= op_d;
      rank_q <= rank_d;
      err_q  <= err_d;
    end
  end

endmodule

// File: tb/tb_srpt_rank_calc.sv
// Directed bench for srpt_rank_calc: ranks, saturation,
// backpressure ordering, interleaved flows and reset.
module tb_srpt_rank_calc;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_flow_id;
  logic [15:0] in_pkt_len;
  logic [31:0] in_flow_size;
  logic        in_first;
  logic        in_last;
  logic [15:0] in_meta;
  logic        busy;
  logic        insert;
  logic [15:0] meta_out;
  logic [1:0]  rank_op_out;
  logic [15:0] srpt_rank_out;
  logic [15:0] err_count;

  int checks = 0;
  int failures = 0;
  logic last_acc;
  logic [31:0] ins_q[$];
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  srpt_rank_calc dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_flow_id(in_flow_id), .in_pkt_len(in_pkt_len),
    .in_flow_size(in_flow_size), .in_first(in_first),
    .in_last(in_last), .in_meta(in_meta),
    .busy(busy), .insert(insert),
    .meta_out(meta_out), .rank_op_out(rank_op_out),
    .srpt_rank_out(srpt_rank_out), .err_count(err_count)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // sample at negedge, then advance past the next posedge
  task automatic tick();
    @(negedge clk);
    last_acc = in_valid & in_ready;
    if (insert) ins_q.push_back({meta_out, srpt_rank_out});
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] id, input logic [15:0] len,
                       input logic [31:0] size, input logic first,
                       input logic last, input logic [15:0] meta);
    in_valid = 1'b1;
    in_flow_id = id;
    in_pkt_len = len;
    in_flow_size = size;
    in_first = first;
    in_last = last;
    in_meta = meta;
  endtask

  task automatic send(input string tag, input logic [3:0] id,
                      input logic [15:0] len, input logic [31:0] size,
                      input logic first, input logic last,
                      input logic [15:0] meta,
                      input logic [15:0] erank, input logic [1:0] eop);
    drive(id, len, size, first, last, meta);
    tick();
    in_valid = 1'b0;
    chk({tag, "_ins"}, 32'(insert), 32'd1);
    chk({tag, "_rank"}, 32'(srpt_rank_out), 32'(erank));
    chk({tag, "_op"}, 32'(rank_op_out), 32'(eop));
    chk({tag, "_meta"}, 32'(meta_out), 32'(meta));
  endtask

  initial begin
    int k;
    int m1, m2, r;
    logic [3:0] id;
    logic [15:0] len;
    rst = 1'b1;
    busy = 1'b0;
    drive(4'd0, 16'd0, 32'd0, 1'b0, 1'b0, 16'd0);
    in_valid = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_insert", 32'(insert), 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd1);
    chk("rst_err", 32'(err_count), 32'd0);

    // unknown non-first flow
    send("t2", 4'd5, 16'd64, 32'd0, 1'b0, 1'b0, 16'h0201,
         16'hFFFF, 2'd1);
    chk("t2_err", 32'(err_count), 32'd1);

    // three-packet flow, back-to-back
    send("t1a", 4'd3, 16'd1000, 32'd3000, 1'b1, 1'b0, 16'h0101,
         16'd3000, 2'd0);
    send("t1b", 4'd3, 16'd1000, 32'd0, 1'b0, 1'b0, 16'h0102,
         16'd2000, 2'd0);
    send("t1c", 4'd3, 16'd1000, 32'd0, 1'b0, 1'b1, 16'h0103,
         16'd1000, 2'd0);
    send("t1d", 4'd3, 16'd10, 32'd0, 1'b0, 1'b0, 16'h0104,
         16'hFFFF, 2'd1);
    chk("t1_err", 32'(err_count), 32'd2);

    // rank saturation and remaining-bytes floor
    send("t4a", 4'd9, 16'd1500, 32'd70000, 1'b1, 1'b0, 16'h0401,
         16'hFFFF, 2'd0);
    send("t4b", 4'd9, 16'd1500, 32'd0, 1'b0, 1'b0, 16'h0402,
         16'hFFFF, 2'd0);
    send("t4c", 4'd10, 16'd500, 32'd800, 1'b1, 1'b0, 16'h0403,
         16'd800, 2'd0);
    send("t4d", 4'd10, 16'd1000, 32'd0, 1'b0, 1'b0, 16'h0404,
         16'd300, 2'd0);
    send("t4e", 4'd10, 16'd100, 32'd0, 1'b0, 1'b0, 16'h0405,
         16'd0, 2'd0);
    send("t4f", 4'd11, 16'd40, 32'd40, 1'b1, 1'b1, 16'h0406,
         16'd40, 2'd0);
    send("t4g", 4'd11, 16'd40, 32'd0, 1'b0, 1'b0, 16'h0407,
         16'hFFFF, 2'd1);

    // backpressure: hold for five cycles, then drain in order
    tick();
    ins_q.delete();
    busy = 1'b1;
    drive(4'd7, 16'd100, 32'd500, 1'b1, 1'b0, 16'h0301);
    tick();
    chk("t3_accA", 32'(last_acc), 32'd1);
    drive(4'd7, 16'd100, 32'd0, 1'b0, 1'b0, 16'h0302);
    for (int c = 0; c < 4; c++) begin
      chk("t3_ready", 32'(in_ready), 32'd0);
      chk("t3_noins", 32'(insert), 32'd0);
      chk("t3_hold", 32'(meta_out), 32'h0301);
      tick();
    end
    busy = 1'b0;
    tick();
    drive(4'd7, 16'd100, 32'd0, 1'b0, 1'b0, 16'h0303);
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    chk("t3_count", ins_q.size(), 32'd3);
    if (ins_q.size() == 3) begin
      chk("t3_o0", ins_q[0], {16'h0301, 16'd500});
      chk("t3_o1", ins_q[1], {16'h0302, 16'd400});
      chk("t3_o2", ins_q[2], {16'h0303, 16'd300});
    end

    // interleaved flows with random busy
    ins_q.delete();
    exp_q.delete();
    k = 0;
    m1 = 0;
    m2 = 0;
    for (int c = 0; c < 300 && k < 10; c++) begin
      id = (k % 2 == 1) ? 4'd2 : 4'd1;
      len = (id == 4'd1) ? 16'd100 : 16'd200;
      drive(id, len, (id == 4'd1) ? 32'd10000 : 32'd5000,
            k < 2, 1'b0, 16'h5000 + 16'(k));
      busy = 1'($urandom_range(0, 1));
      tick();
      if (last_acc) begin
        if (id == 4'd1) begin
          r = (k < 2) ? 10000 : m1;
          m1 = r - 100;
        end else begin
          r = (k < 2) ? 5000 : m2;
          m2 = r - 200;
        end
        exp_q.push_back({16'h5000 + 16'(k), 16'(r)});
        k++;
      end
    end
    in_valid = 1'b0;
    busy = 1'b0;
    tick();
    tick();
    chk("t5_acc", 32'(k), 32'd10);
    chk("t5_count", ins_q.size(), exp_q.size());
    for (int i = 0; i < 10; i++)
      if (i < ins_q.size() && i < exp_q.size())
        chk("t5_entry", ins_q[i], exp_q[i]);

    // reset while pending and busy
    send("t6a", 4'd4, 16'd10, 32'd1000, 1'b1, 1'b0, 16'h0601,
         16'd1000, 2'd0);
    busy = 1'b1;
    drive(4'd4, 16'd10, 32'd0, 1'b0, 1'b0, 16'h0602);
    tick();
    in_valid = 1'b0;
    chk("t6_pend", 32'(in_ready), 32'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    busy = 1'b0;
    chk("t6_insert", 32'(insert), 32'd0);
    chk("t6_ready", 32'(in_ready), 32'd1);
    chk("t6_err", 32'(err_count), 32'd0);
    send("t6b", 4'd4, 16'd10, 32'd0, 1'b0, 1'b0, 16'h0603,
         16'hFFFF, 2'd1);
    chk("t6_err1", 32'(err_count), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
